id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  Decode-to-execute pipeline register with load-use hazard detection.
//  Captures register-file read data (RD1/RD2), immediate, PC, register numbers and the control bundle at posedge clk.
//  Register file is written/read on negedge, so WB->ID same-cycle data is already current here.
//  Inserts a bubble and stalls IF/ID on load-use, zeroes the stage on branch flush, counts both events.
// PARAMETERS
//  XLEN        64  datapath width (pc, rd1, rd2, imm)
//  RADDR_W     5   register-number width
//  CNT_W       32  width of stall/flush event counters
// PORTS
//  clk           in   1        rising-edge clock
//  reset         in   1        synchronous, active-high reset
//  flush         in   1        branch taken in EX/MEM; kill the instruction entering EX
//  id_valid      in   1        ID holds a real instruction
//  id_pc         in   XLEN     PC of ID instruction
//  id_rd1/id_rd2 in   XLEN     register-file read data
//  id_imm        in   XLEN     sign-extended immediate
//  id_rs1/id_rs2 in   RADDR_W  source register numbers
//  id_rd         in   RADDR_W  destination register number
//  id_ctrl       in   9        {RegWrite,MemRead,MemWrite,MemtoReg,ALUSrc,Branch,ALUOp[1:0],Uses_rs2}
//  ex_valid      out  1        EX holds a real instruction
//  ex_pc/ex_rd1/ex_rd2/ex_imm out XLEN   registered copies
//  ex_rs1/ex_rs2/ex_rd        out RADDR_W registered copies
//  ex_ctrl       out  9        registered control bundle
//  stall         out  1        combinational; hold PC and IF/ID this cycle
//  stall_cnt     out  CNT_W    number of load-use bubbles inserted
//  flush_cnt     out  CNT_W    number of flush bubbles inserted
// BEHAVIOUR
//  Reset: every ex_* output = 0, ex_valid = 0, both counters = 0. stall still follows its equation, which is 0 because ex_valid = 0.
//  hazard = ex_valid & ex_ctrl.MemRead & (ex_rd != 0) & id_valid &
//           ((ex_rd == id_rs1) | (id_ctrl.Uses_rs2 & (ex_rd == id_rs2))).
//  stall = hazard & ~flush. Flush kills ID, so no stall is needed.
//  Posedge priority (highest first):
//   1 reset: clear all state as above.
//   2 flush: bubble. ex_valid=0; ex_ctrl=0; data fields=0; flush_cnt+1.
//   3 hazard: bubble as in 2, but stall_cnt+1. ID is held upstream and re-presented next cycle.
//   4 normal: capture all id_* fields; ex_valid=id_valid. If id_valid=0, ex_ctrl is forced to 0.
//  Latency: 1 cycle ID->EX. A load followed by a dependent op produces exactly one bubble.
//  On the next cycle the bubble has ex_valid=0, so hazard drops and the dependent op advances.
//  x0 never triggers a hazard. A load writing x0 followed by a read of x0 gives no stall.
//  flush and hazard in the same cycle: only flush_cnt increments.
//  Counters saturate at all-ones and never wrap.
//  Reset asserted mid-stall: the next edge clears state and stall deasserts combinationally.
//  The control of any bubble is all-zero, so no RegWrite or MemWrite reaches later stages.
// STRUCTURE
//  Package pipe_pkg holds:
//   - CTRL_W=9 and bit-index localparams (CTRL_REGWRITE..CTRL_USES_RS2);
//   - ALUOp encodings (2'b00 ld/sd, 2'b01 branch, 2'b10 R-type);
//   - XLEN and RADDR_W defaults.
//  Sub-module load_use_detect (pure combinational): inputs ex_valid, ex_memread, ex_rd, id_valid, id_rs1, id_rs2, id_uses_rs2; output hazard.
//  Top level holds the pipeline flops and the saturating counters.
// TESTING
//  1 Reset held 2 cycles with random id_* -> all ex_*=0, ex_valid=0, counters=0.
//  2 ld x5 (MemRead=1, rd=5), then add rs1=5 -> stall=1 for one cycle, ex_valid=0 after edge,
//    stall_cnt=1, add appears in EX next edge with ex_rs1=5.
//  3 ld rd=0, then rs1=0 -> stall=0, no bubble, stall_cnt=0.
//  4 ld rd=7, then sd rs2=7 with Uses_rs2=0 (in a variant test) -> no stall;
//    with Uses_rs2=1 -> stall.
//  5 flush=1 coincident with hazard -> stall=0, ex_ctrl=0, flush_cnt=1, stall_cnt=0.
//  6 Preload stall_cnt near 2^CNT_W-1 via forced hazards (CNT_W=4) -> saturates at 4'hF.
//  7 Normal stream of 3 R-type ops, id_rd1=20, id_rd2=16 -> ex_rd1=20, ex_rd2=16 one cycle later,
//    no stalls.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared widths, control-bundle bit positions and ALUOp encodings
package pipe_pkg;
    localparam int XLEN_DEF    = 64;
    localparam int RADDR_W_DEF = 5;
    localparam int CTRL_W      = 9;
    localparam int CTRL_REGWRITE = 8;
    localparam int CTRL_MEMREAD  = 7;
    localparam int CTRL_MEMWRITE = 6;
    localparam int CTRL_MEMTOREG = 5;
    localparam int CTRL_ALUSRC   = 4;
    localparam int CTRL_BRANCH   = 3;
    localparam int CTRL_ALUOP_HI = 2;
    localparam int CTRL_ALUOP_LO = 1;
    localparam int CTRL_USES_RS2 = 0;
    localparam logic [1:0] ALUOP_LDSD   = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags an ID instruction that reads the register a load in EX is still fetching
//   ex_valid/ex_memread/ex_rd : instruction currently in EX
//   id_valid/id_rs1/id_rs2/id_uses_rs2 : instruction currently in ID
//   hazard : combinational load-use hazard
module load_use_detect
    import pipe_pkg::*;
#(
    parameter int RADDR_W = RADDR_W_DEF
) (
    input  logic               ex_valid,
    input  logic               ex_memread,
    input  logic [RADDR_W-1:0] ex_rd,
    input  logic               id_valid,
    input  logic [RADDR_W-1:0] id_rs1,
    input  logic [RADDR_W-1:0] id_rs2,
    input  logic               id_uses_rs2,
    output logic               hazard
);
    // x0 is hardwired to zero, so a load targeting it can never produce a dependency
    assign hazard = ex_valid & ex_memread & (ex_rd != '0) & id_valid &
                    ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2)));
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID->EX pipeline register with load-use bubble insertion, flush, and event counters
//   clk, reset (sync, active-high), flush (kill instruction entering EX)
//   id_* : decoded instruction fields; ex_* : registered copies
//   stall : hold PC and IF/ID this cycle; stall_cnt/flush_cnt : saturating bubble counters
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int RADDR_W = RADDR_W_DEF,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               id_valid,
    input  logic [XLEN-1:0]    id_pc,
    input  logic [XLEN-1:0]    id_rd1,
    input  logic [XLEN-1:0]    id_rd2,
    input  logic [XLEN-1:0]    id_imm,
    input  logic [RADDR_W-1:0] id_rs1,
    input  logic [RADDR_W-1:0] id_rs2,
    input  logic [RADDR_W-1:0] id_rd,
    input  logic [CTRL_W-1:0]  id_ctrl,
    output logic               ex_valid,
    output logic [XLEN-1:0]    ex_pc,
    output logic [XLEN-1:0]    ex_rd1,
    output logic [XLEN-1:0]    ex_rd2,
    output logic [XLEN-1:0]    ex_imm,
    output logic [RADDR_W-1:0] ex_rs1,
    output logic [RADDR_W-1:0] ex_rs2,
    output logic [RADDR_W-1:0] ex_rd,
    output logic [CTRL_W-1:0]  ex_ctrl,
    output logic               stall,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);
    logic               hazard, bubble;
    logic               valid_q, valid_d;
    logic [XLEN-1:0]    pc_q, pc_d, rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
    logic [RADDR_W-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    load_use_detect #(.RADDR_W(RADDR_W)) u_detect (
        .ex_valid    (valid_q),
        .ex_memread  (ctrl_q[CTRL_MEMREAD]),
        .ex_rd       (rd_q),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs2 (id_ctrl[CTRL_USES_RS2]),
        .hazard      (hazard)
    );

    // flush already discards ID, so holding IF/ID for a hazard would be pointless
    assign stall  = hazard & ~flush;
    assign bubble = flush | hazard;

    always_comb begin
        valid_d     = ~bubble & id_valid;
        ctrl_d      = (bubble | ~id_valid) ? '0 : id_ctrl;
        pc_d        = bubble ? '0 : id_pc;
        rd1_d       = bubble ? '0 : id_rd1;
        rd2_d       = bubble ? '0 : id_rd2;
        imm_d       = bubble ? '0 : id_imm;
        rs1_d       = bubble ? '0 : id_rs1;
        rs2_d       = bubble ? '0 : id_rs2;
        rd_d        = bubble ? '0 : id_rd;
        flush_cnt_d = (flush & ~&flush_cnt_q) ? flush_cnt_q + 1'b1 : flush_cnt_q;
        stall_cnt_d = (stall & ~&stall_cnt_q) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q     <= 1'b0;
            ctrl_q      <= '0;
            pc_q        <= '0;
            rd1_q       <= '0;
            rd2_q       <= '0;
            imm_q       <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            valid_q     <= valid_d;
            ctrl_q      <= ctrl_d;
            pc_q        <= pc_d;
            rd1_q       <= rd1_d;
            rd2_q       <= rd2_d;
            imm_q       <= imm_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign ex_valid  = valid_q;
    assign ex_ctrl   = ctrl_q;
    assign ex_pc     = pc_q;
    assign ex_rd1    = rd1_q;
    assign ex_rd2    = rd2_q;
    assign ex_imm    = imm_q;
    assign ex_rs1    = rs1_q;
    assign ex_rs2    = rs2_q;
    assign ex_rd     = rd_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed self-checking bench for id_ex_stage
module tb_id_ex_stage;
    localparam int XLEN = 64;
    localparam int RW   = 5;
    localparam int CW   = 4;
    localparam logic [8:0] C_LD     = 9'h1B0;
    localparam logic [8:0] C_ADD    = 9'h105;
    localparam logic [8:0] C_SD     = 9'h051;
    localparam logic [8:0] C_SD_NO2 = 9'h050;

    logic            clk = 1'b0;
    logic            reset, flush, id_valid;
    logic [XLEN-1:0] id_pc, id_rd1, id_rd2, id_imm;
    logic [RW-1:0]   id_rs1, id_rs2, id_rd;
    logic [8:0]      id_ctrl;
    logic            ex_valid, stall;
    logic [XLEN-1:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
    logic [RW-1:0]   ex_rs1, ex_rs2, ex_rd;
    logic [8:0]      ex_ctrl;
    logic [CW-1:0]   stall_cnt, flush_cnt;
    int checks = 0;
    int failures = 0;

    id_ex_stage #(.XLEN(XLEN), .RADDR_W(RW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .flush(flush), .id_valid(id_valid),
        .id_pc(id_pc), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_ctrl(id_ctrl),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
        .stall(stall), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [RW-1:0] rs1, input logic [RW-1:0] rs2,
                         input logic [RW-1:0] rd, input logic [8:0] ctrl);
        id_valid = v;
        id_rs1   = rs1;
        id_rs2   = rs2;
        id_rd    = rd;
        id_ctrl  = ctrl;
        id_pc    = 64'h1000 + {59'd0, rd};
        id_rd1   = 64'd20;
        id_rd2   = 64'd16;
        id_imm   = 64'hFFFF_FFFF_FFFF_FFF8;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        flush    = 1'b0;
        id_valid = 1'b1;
        id_pc    = {$urandom, $urandom};
        id_rd1   = {$urandom, $urandom};
        id_rd2   = {$urandom, $urandom};
        id_imm   = {$urandom, $urandom};
        id_rs1   = RW'($urandom);
        id_rs2   = RW'($urandom);
        id_rd    = RW'($urandom);
        id_ctrl  = 9'h1FF;
        step();
        step();
        checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0h exp=0", ex_valid); end
        checks++; if (ex_ctrl !== 9'h0) begin failures++; $display("FAIL reset_ctrl got=%0h exp=0", ex_ctrl); end
        checks++; if ({ex_pc, ex_rd1, ex_rd2, ex_imm} !== '0) begin failures++; $display("FAIL reset_data got=%0h/%0h/%0h/%0h exp=0", ex_pc, ex_rd1, ex_rd2, ex_imm); end
        checks++; if ({ex_rs1, ex_rs2, ex_rd} !== '0) begin failures++; $display("FAIL reset_regs got=%0h/%0h/%0h exp=0", ex_rs1, ex_rs2, ex_rd); end
        checks++; if ({stall_cnt, flush_cnt} !== '0) begin failures++; $display("FAIL reset_cnt got=%0h/%0h exp=0", stall_cnt, flush_cnt); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0h exp=0", stall); end
        reset = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 9'h0);
        step();
    endtask

    task automatic test_load_use();
        drive(1'b1, 5'd1, 5'd0, 5'd5, C_LD);
        step();
        checks++; if (ex_valid !== 1'b1 || ex_rd !== 5'd5 || ex_ctrl !== C_LD) begin failures++; $display("FAIL lu_load got=%0h/%0h/%0h exp=1/5/%0h", ex_valid, ex_rd, ex_ctrl, C_LD); end
        drive(1'b1, 5'd5, 5'd6, 5'd8, C_ADD);
        #1;
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL lu_stall got=%0h exp=1", stall); end
        step();
        checks++; if (ex_valid !== 1'b0 || ex_ctrl !== 9'h0) begin failures++; $display("FAIL lu_bubble got=%0h/%0h exp=0/0", ex_valid, ex_ctrl); end
        checks++; if (stall_cnt !== 4'd1) begin failures++; $display("FAIL lu_cnt got=%0d exp=1", stall_cnt); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL lu_stall_drop got=%0h exp=0", stall); end
        step();
        checks++; if (ex_valid !== 1'b1 || ex_rs1 !== 5'd5 || ex_ctrl !== C_ADD || ex_rd !== 5'd8) begin failures++; $display("FAIL lu_advance got=%0h/%0h/%0h/%0h exp=1/5/%0h/8", ex_valid, ex_rs1, ex_ctrl, ex_rd, C_ADD); end
    endtask

    task automatic test_x0();
        drive(1'b1, 5'd2, 5'd0, 5'd0, C_LD);
        step();
        drive(1'b1, 5'd0, 5'd0, 5'd9, C_ADD);
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL x0_stall got=%0h exp=0", stall); end
        step();
        checks++; if (ex_valid !== 1'b1 || ex_rs1 !== 5'd0 || stall_cnt !== 4'd1) begin failures++; $display("FAIL x0_nobubble got=%0h/%0h/%0d exp=1/0/1", ex_valid, ex_rs1, stall_cnt); end
    endtask

    task automatic test_uses_rs2();
        drive(1'b1, 5'd2, 5'd0, 5'd7, C_LD);
        step();
        drive(1'b1, 5'd1, 5'd7, 5'd0, C_SD_NO2);
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rs2_unused_stall got=%0h exp=0", stall); end
        step();
        checks++; if (ex_valid !== 1'b1 || stall_cnt !== 4'd1) begin failures++; $display("FAIL rs2_unused_adv got=%0h/%0d exp=1/1", ex_valid, stall_cnt); end
        drive(1'b1, 5'd2, 5'd0, 5'd7, C_LD);
        step();
        drive(1'b1, 5'd1, 5'd7, 5'd0, C_SD);
        #1;
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL rs2_used_stall got=%0h exp=1", stall); end
        step();
        checks++; if (ex_valid !== 1'b0 || ex_ctrl !== 9'h0 || stall_cnt !== 4'd2) begin failures++; $display("FAIL rs2_used_bubble got=%0h/%0h/%0d exp=0/0/2", ex_valid, ex_ctrl, stall_cnt); end
        step();
        checks++; if (ex_valid !== 1'b1 || ex_ctrl !== C_SD || ex_rs2 !== 5'd7) begin failures++; $display("FAIL rs2_used_adv got=%0h/%0h/%0h exp=1/%0h/7", ex_valid, ex_ctrl, ex_rs2, C_SD); end
    endtask

    task automatic test_flush();
        drive(1'b1, 5'd2, 5'd0, 5'd9, C_LD);
        step();
        drive(1'b1, 5'd9, 5'd0, 5'd3, C_ADD);
        flush = 1'b1;
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL flush_stall got=%0h exp=0", stall); end
        step();
        flush = 1'b0;
        checks++; if (ex_valid !== 1'b0 || ex_ctrl !== 9'h0 || ex_pc !== '0 || ex_rd1 !== '0) begin failures++; $display("FAIL flush_bubble got=%0h/%0h/%0h/%0h exp=0/0/0/0", ex_valid, ex_ctrl, ex_pc, ex_rd1); end
        checks++; if (flush_cnt !== 4'd1 || stall_cnt !== 4'd2) begin failures++; $display("FAIL flush_cnt got=%0d/%0d exp=1/2", flush_cnt, stall_cnt); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 14; i++) begin
            drive(1'b1, 5'd2, 5'd0, 5'd3, C_LD);
            step();
            drive(1'b1, 5'd3, 5'd0, 5'd4, C_ADD);
            step();
            if (i == 12) begin
                checks++; if (stall_cnt !== 4'hF) begin failures++; $display("FAIL sat_reach got=%0h exp=f", stall_cnt); end
            end
        end
        checks++; if (stall_cnt !== 4'hF) begin failures++; $display("FAIL sat_hold got=%0h exp=f", stall_cnt); end
        drive(1'b0, 5'd0, 5'd0, 5'd0, 9'h0);
        step();
    endtask

    task automatic test_stream();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'd1 + 5'(i), 5'd2 + 5'(i), 5'd10 + 5'(i), C_ADD);
            #1;
            checks++; if (stall !== 1'b0) begin failures++; $display("FAIL stream_stall%0d got=%0h exp=0", i, stall); end
            step();
            checks++; if (ex_rd1 !== 64'd20 || ex_rd2 !== 64'd16 || ex_valid !== 1'b1 || ex_rd !== 5'd10 + 5'(i)) begin failures++; $display("FAIL stream_data%0d got=%0d/%0d/%0h/%0d exp=20/16/1/%0d", i, ex_rd1, ex_rd2, ex_valid, ex_rd, 10 + i); end
            checks++; if (ex_pc !== 64'h1000 + 64'(10 + i) || ex_imm !== 64'hFFFF_FFFF_FFFF_FFF8) begin failures++; $display("FAIL stream_pcimm%0d got=%0h/%0h exp=%0h/fffffffffffffff8", i, ex_pc, ex_imm, 64'h1000 + 64'(10 + i)); end
        end
    endtask

    task automatic test_idle_ctrl();
        drive(1'b0, 5'd1, 5'd2, 5'd6, C_ADD);
        step();
        checks++; if (ex_valid !== 1'b0 || ex_ctrl !== 9'h0 || ex_pc !== 64'h1006) begin failures++; $display("FAIL idle_ctrl got=%0h/%0h/%0h exp=0/0/1006", ex_valid, ex_ctrl, ex_pc); end
    endtask

    task automatic test_reset_mid_stall();
        drive(1'b1, 5'd2, 5'd0, 5'd4, C_LD);
        step();
        drive(1'b1, 5'd4, 5'd0, 5'd5, C_ADD);
        reset = 1'b1;
        #1;
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL rst_mid_pre got=%0h exp=1", stall); end
        step();
        checks++; if (stall !== 1'b0 || ex_valid !== 1'b0 || stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin failures++; $display("FAIL rst_mid_post got=%0h/%0h/%0d/%0d exp=0/0/0/0", stall, ex_valid, stall_cnt, flush_cnt); end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_x0();
        test_uses_rs2();
        test_flush();
        test_saturation();
        test_stream();
        test_idle_ctrl();
        test_reset_mid_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
